// File: rtl/sdrc_wbm_pkg.sv
// Shared constants for the sdrc Wishbone burst master: FSM encodings, cycle types
// and the Galois LFSR (x^32+x^22+x^2+x+1) used for the data pattern.
package sdrc_wbm_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  // Right-shifting Galois form: taps 32,22,2,1 land on bits 31,21,1,0.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/sdrc_wb_burst_master_if.sv
// Wishbone initiator-side bus bundle between the burst master and the sdrc_top slave port.
interface sdrc_wb_burst_master_if #(
  parameter int APP_AW = 26,
  parameter int WB_DW  = 32
);
  logic                 wb_cyc_o;
  logic                 wb_stb_o;
  logic                 wb_we_o;
  logic [APP_AW-1:0]    wb_addr_o;
  logic [WB_DW-1:0]     wb_dat_o;
  logic [WB_DW/8-1:0]   wb_sel_o;
  logic [2:0]           wb_cti_o;
  logic                 wb_ack_i;
  logic [WB_DW-1:0]     wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/sdrc_wbm_lfsr.sv
// Pattern generator: one instance feeds both write data and the read-check expectation.
module sdrc_wbm_lfsr
  import sdrc_wbm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state <= '0;
    else if (load) state <= (seed == '0) ? 32'h1 : seed;
    else if (step) state <= lfsr_next(state);
  end

endmodule

// File: rtl/sdrc_wb_burst_master.sv
// Wishbone burst master: runs one write or read+check burst per command with an LFSR pattern.
// Optional per-beat ack watchdog is built when WB_ACK_TIMEOUT_EN is defined.
module sdrc_wb_burst_master
  import sdrc_wbm_pkg::*;
#(
  parameter  int APP_AW      = 26,
  parameter  int WB_DW       = 32,
  parameter  int MAX_LEN     = 256,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int LW          = $clog2(MAX_LEN + 1)
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [APP_AW-1:0]     cmd_addr,
  input  logic [LW-1:0]         cmd_len,
  input  logic [31:0]           cmd_seed,
  sdrc_wb_burst_master_if.master wb,
  output logic                  done,
  output logic [15:0]           err_cnt,
  output logic                  timeout
);

  logic [1:0]        state;
  logic              we_r;
  logic [APP_AW-1:0] addr_r;
  logic [LW-1:0]     len_r;
  logic [LW-1:0]     beat_cnt;
  logic [31:0]       pat;
  logic              bus, accept, beat_ack, last_beat, to_hit;

  assign bus       = (state == BUS);
  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign beat_ack  = bus & wb.wb_ack_i;
  assign last_beat = (beat_cnt == len_r - 1'b1);
  assign done      = (state == DONE);

  sdrc_wbm_lfsr u_lfsr (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .load  (accept),
    .step  (beat_ack),
    .seed  (cmd_seed),
    .state (pat)
  );

`ifdef WB_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          to_r;

  // Counts consecutive bus cycles without ack; the last allowed cycle aborts the burst.
  assign to_hit  = bus & ~wb.wb_ack_i & (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign timeout = to_r;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt <= '0;
      to_r   <= 1'b0;
    end else begin
      if (accept) begin
        to_cnt <= '0;
        to_r   <= 1'b0;
      end else if (bus) begin
        to_cnt <= wb.wb_ack_i ? '0 : to_cnt + 1'b1;
      end
      if (to_hit) to_r <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  // Watchdog not built: output tied low, parameter kept so both builds share one interface.
  assign timeout = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      we_r     <= 1'b0;
      addr_r   <= '0;
      len_r    <= '0;
      beat_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          state    <= BUS;
          we_r     <= cmd_we;
          addr_r   <= {cmd_addr[APP_AW-1:2], 2'b00};
          len_r    <= (cmd_len == '0) ? LW'(1) : cmd_len;
          beat_cnt <= '0;
          err_cnt  <= '0;
        end
        BUS: begin
          if (wb.wb_ack_i) begin
            beat_cnt <= beat_cnt + 1'b1;
            addr_r   <= addr_r + APP_AW'(4);
            if (!we_r && wb.wb_dat_i != WB_DW'(pat) && err_cnt != 16'hFFFF)
              err_cnt <= err_cnt + 16'd1;
            if (last_beat) state <= DONE;
          end else if (to_hit) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb.wb_cyc_o  = bus;
  assign wb.wb_stb_o  = bus;
  assign wb.wb_we_o   = bus & we_r;
  assign wb.wb_addr_o = addr_r;
  assign wb.wb_dat_o  = (bus & we_r) ? WB_DW'(pat) : '0;
  assign wb.wb_sel_o  = {(WB_DW/8){bus}};
  assign wb.wb_cti_o  = (!bus || len_r == LW'(1)) ? CTI_CLASSIC :
                        last_beat                 ? CTI_END     : CTI_INCR;

endmodule
